// File: rtl/aes_encipher_round.sv
// One AES-128 encryption round: SubBytes via external S-box, ShiftRows, MixColumns, AddRoundKey.
// Define AES_FINAL_ROUND_EN to bypass MixColumns (AES round 10); latency stays 3 cycles.
module aes_encipher_round (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] input_block,
  input  logic [127:0] round_key,
  output logic [127:0] old_sbox,
  input  logic [127:0] new_sbox,
  output logic [127:0] output_block,
  output logic         output_ctrl,
  output logic         ready
);

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} fsm_t;

  fsm_t         fsm_reg, fsm_next;
  logic [127:0] state_reg, state_next;
  logic [127:0] out_reg, out_next;
  logic         ready_reg, ready_next;
  logic         ctrl_reg, ctrl_next;

  logic [127:0] shifted;
  logic [127:0] round_core;

  // ShiftRows: byte (col c, row r) comes from column (c + r) mod 4 of the same row.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    for (genvar gj = 0; gj < 4; gj++) begin : g_row
      assign shifted[127-8*(4*gi+gj) -: 8] = state_reg[127-8*(4*((gi+gj)%4)+gj) -: 8];
    end
  end

`ifdef AES_FINAL_ROUND_EN
  assign round_core = shifted;
`else
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [127:0] mixed;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] s0, s1, s2, s3;
    assign s0 = shifted[127-32*gi -: 8];
    assign s1 = shifted[119-32*gi -: 8];
    assign s2 = shifted[111-32*gi -: 8];
    assign s3 = shifted[103-32*gi -: 8];
    assign mixed[127-32*gi -: 8] = xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3;
    assign mixed[119-32*gi -: 8] = s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3;
    assign mixed[111-32*gi -: 8] = s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3;
    assign mixed[103-32*gi -: 8] = xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3);
  end

  assign round_core = mixed;
`endif

  always_comb begin
    fsm_next   = fsm_reg;
    state_next = state_reg;
    out_next   = out_reg;
    ready_next = ready_reg;
    ctrl_next  = 1'b0;
    case (fsm_reg)
      IDLE: begin
        state_next = input_block;
        fsm_next   = SUB;
      end
      SUB: begin
        state_next = new_sbox;
        fsm_next   = MIX;
      end
      MIX: begin
        out_next   = round_core ^ round_key;
        ready_next = 1'b1;
        ctrl_next  = 1'b1;
        fsm_next   = DONE;
      end
      DONE: begin
        fsm_next = DONE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  // Reset input is active-high even though it carries the legacy _n name.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      fsm_reg   <= IDLE;
      state_reg <= '0;
      out_reg   <= '0;
      ready_reg <= 1'b0;
      ctrl_reg  <= 1'b0;
    end else begin
      fsm_reg   <= fsm_next;
      state_reg <= state_next;
      out_reg   <= out_next;
      ready_reg <= ready_next;
      ctrl_reg  <= ctrl_next;
    end
  end

  assign old_sbox     = state_reg;
  assign output_block = out_reg;
  assign output_ctrl  = ctrl_reg;
  assign ready        = ready_reg;

endmodule

// File: tb/tb_aes_encipher_round.sv
// Directed-vector bench for aes_encipher_round; provides the shared S-box as a combinational model.
module tb_aes_encipher_round;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [127:0] input_block = '0;
  logic [127:0] round_key = '0;
  logic [127:0] old_sbox;
  logic [127:0] new_sbox;
  logic [127:0] output_block;
  logic         output_ctrl;
  logic         ready;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  aes_encipher_round dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .input_block  (input_block),
    .round_key    (round_key),
    .old_sbox     (old_sbox),
    .new_sbox     (new_sbox),
    .output_block (output_block),
    .output_ctrl  (output_ctrl),
    .ready        (ready)
  );

  localparam logic [127:0] SBOX_ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [127:0] row;
    row = SBOX_ROWS[x[7:4]];
    return row[127-8*int'(x[3:0]) -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_byte(s[127-8*i -: 8]);
    return r;
  endfunction

  always_comb begin
    new_sbox = '0;
    new_sbox = sub_bytes(old_sbox);
  end

  typedef struct {
    string        name;
    logic [127:0] blk;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "/out"},   output_block,        128'd0);
    check({tag, "/ready"}, 128'(ready),         128'd0);
    check({tag, "/ctrl"},  128'(output_ctrl),   128'd0);
    check({tag, "/sbox"},  old_sbox,            128'd0);
  endtask

  // Full round from a fresh reset; inputs change on negedges, outputs sampled on negedges.
  task automatic run_round(input vec_t v);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_cleared({v.name, "/rst"});
    reset_n     = 1'b0;
    input_block = v.blk;
    round_key   = v.key;
    @(negedge clk);
    check({v.name, "/e1_ready"}, 128'(ready), 128'd0);
    check({v.name, "/e1_ctrl"},  128'(output_ctrl), 128'd0);
    check({v.name, "/e1_sbox"},  old_sbox, v.blk);
    input_block = ~v.blk;
    @(negedge clk);
    check({v.name, "/e2_ready"}, 128'(ready), 128'd0);
    check({v.name, "/e2_ctrl"},  128'(output_ctrl), 128'd0);
    check({v.name, "/e2_sbox"},  old_sbox, sub_bytes(v.blk));
    @(negedge clk);
    check({v.name, "/e3_ready"}, 128'(ready), 128'd1);
    check({v.name, "/e3_ctrl"},  128'(output_ctrl), 128'd1);
    check({v.name, "/e3_out"},   output_block, v.exp);
    @(negedge clk);
    check({v.name, "/e4_ready"}, 128'(ready), 128'd1);
    check({v.name, "/e4_ctrl"},  128'(output_ctrl), 128'd0);
    check({v.name, "/e4_out"},   output_block, v.exp);
    $display("round %s in=%h key=%h out=%h", v.name, v.blk, v.key, output_block);
  endtask

  // Start a round, then reassert reset after n_edges start edges.
  task automatic abort_round(input vec_t v, input int n_edges);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    reset_n     = 1'b0;
    input_block = v.blk;
    round_key   = v.key;
    for (int i = 0; i < n_edges; i++) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_cleared($sformatf("abort%0d", n_edges));
    for (int i = 0; i < 3; i++) @(negedge clk);
    check_cleared($sformatf("abort%0d_hold", n_edges));
    $display("abort after %0d edges: out=%h ready=%0d", n_edges, output_block, ready);
  endtask

  initial begin
    vec_t v;
    int   ctrl_hits;
    logic [127:0] held;

    v.name = "fips_r1";
    v.blk  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    v.key  = 128'ha0fafe1788542cb123a339392a6c7605;
`ifdef AES_FINAL_ROUND_EN
    v.exp  = 128'h7445a32768e07e1f9be228c8344beee0;
`else
    v.exp  = 128'ha49c7ff2689f352b6b5bea43026a5049;
`endif
    vecs.push_back(v);
    v.name = "zero";
    v.blk  = '0;
    v.key  = '0;
    v.exp  = {16{8'h63}};
    vecs.push_back(v);
`ifdef AES_FINAL_ROUND_EN
    v.name = "fips_r10";
    v.blk  = 128'heb40f21e592e38848ba113e71bc342d2;
    v.key  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    v.exp  = 128'h3925841d02dc09fbdc118597196a0b32;
    vecs.push_back(v);
`endif

    repeat (3) @(negedge clk);
    check_cleared("reset");

    foreach (vecs[i]) run_round(vecs[i]);

    // Hold: DONE ignores input changes and keeps the result for twenty cycles.
    run_round(vecs[0]);
    held      = output_block;
    ctrl_hits = 0;
    for (int i = 0; i < 20; i++) begin
      input_block = {$urandom, $urandom, $urandom, $urandom};
      round_key   = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (output_ctrl) ctrl_hits++;
    end
    check("hold/ready", 128'(ready), 128'd1);
    check("hold/out", output_block, vecs[0].exp);
    check("hold/out_stable", output_block, held);
    check("hold/ctrl_hits", 128'(ctrl_hits), 128'd0);
    $display("hold 20 cycles: out=%h ready=%0d strobes=%0d", output_block, ready, ctrl_hits);

    // Reset while in DONE clears everything.
    reset_n = 1'b1;
    @(negedge clk);
    check_cleared("rst_done");
    $display("reset in DONE: out=%h ready=%0d", output_block, ready);

    abort_round(vecs[0], 2);
    run_round(vecs[0]);
    abort_round(vecs[0], 1);
    run_round(vecs[1]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
